// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: arbiter state encoding and parameter defaults shared by the
// PSRAM arbiter and its round-robin picker.
package psram_arb_pkg;

    typedef enum bit [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_ISSUE     = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_ACK       = 3'd4
    } ArbState;

    localparam int ADDR_W_DEF         = 24;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int TIMEOUT_CNT_W      = 16;

endpackage

// File: rtl/psram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Scans last+1, last+2, ...
// modulo NUM_REQ and returns the first requesting index as one-hot and binary.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Rotating priority scan starting just after the previous owner
    always_comb begin
        int k;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(last) + i) % NUM_REQ;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                idx      = IDX_W'(k);
                grant[k] = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PSRAM controller between NUM_REQ requesters.
// Round-robin grant, one transaction at a time, drives the controller
// chip-enable handshake and returns read data plus a one-cycle ack.
// Optional feature macro: PSRAM_ARB_TIMEOUT_EN (abort when busy never rises).
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clkSys,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ-1:0]      i_write,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ-1:0]      i_bank,
    input  logic [NUM_REQ*8-1:0]    i_wdata,
    output logic [NUM_REQ-1:0]      o_ack,
    output logic [NUM_REQ-1:0]      o_err,
    output logic [7:0]              o_rdata,
    output logic [NUM_REQ-1:0]      o_grant,
    output logic                    o_mem_cs_n,
    output logic                    o_mem_write,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic                    o_mem_bank,
    output logic [7:0]              o_mem_wdata,
    input  logic [7:0]              i_mem_rdata,
    input  logic                    i_mem_busy,
    input  logic                    i_mem_ready,
    input  logic                    i_mem_idle
);

    localparam int IDX_W = $clog2(NUM_REQ);

    ArbState              state_r;
    ArbState              state_nxt_s;
    logic [IDX_W-1:0]     last_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic [7:0]           rdata_r;
    logic                 mem_cs_n_r;
    logic                 mem_write_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic                 mem_bank_r;
    logic [7:0]           mem_wdata_r;

    logic [NUM_REQ-1:0]   pick_grant_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_valid_s;
    logic                 load_s;
    logic                 capture_s;
    logic                 ack_set_s;
    logic                 err_set_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (i_req),
        .last  (last_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

`ifdef PSRAM_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] tmo_cnt_r;
    logic [NUM_REQ-1:0]       err_r;

    // Count cycles spent waiting for the controller to raise busy
    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ARB_WAIT_BUSY) begin
            tmo_cnt_r <= tmo_cnt_r + TIMEOUT_CNT_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // One-cycle error pulse to the owner of an aborted transaction
    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            err_r <= '0;
        end else begin
            err_r <= err_set_s ? grant_r : '0;
        end
    end

    assign o_err = err_r;
`else
    assign o_err = {NUM_REQ{1'b0}};
`endif

    // State register
    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        ack_set_s   = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s && i_mem_idle && !i_mem_busy) begin
                    state_nxt_s = ARB_ISSUE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                state_nxt_s = ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
                if (i_mem_busy) begin
                    state_nxt_s = ARB_WAIT_DONE;
`ifdef PSRAM_ARB_TIMEOUT_EN
                end else if (tmo_cnt_r == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt_s = ARB_IDLE;
                    err_set_s   = 1'b1;
`endif
                end else begin
                    state_nxt_s = ARB_WAIT_BUSY;
                end
            end
            ARB_WAIT_DONE: begin
                if (!i_mem_busy && (mem_write_r || i_mem_ready)) begin
                    state_nxt_s = ARB_ACK;
                    ack_set_s   = 1'b1;
                    capture_s   = !mem_write_r;
                end else begin
                    state_nxt_s = ARB_WAIT_DONE;
                end
            end
            ARB_ACK: begin
                state_nxt_s = ARB_IDLE;
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Latch the winner's payload at grant and drive the registered outputs
    always_ff @(posedge clkSys or negedge rst) begin
        if (!rst) begin
            last_r      <= IDX_W'(NUM_REQ - 1);
            grant_r     <= '0;
            ack_r       <= '0;
            rdata_r     <= 8'h00;
            mem_cs_n_r  <= 1'b1;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_bank_r  <= 1'b0;
            mem_wdata_r <= 8'h00;
        end else begin
            mem_cs_n_r <= !load_s;
            ack_r      <= ack_set_s ? grant_r : '0;
            if (load_s) begin
                grant_r     <= pick_grant_s;
                last_r      <= pick_idx_s;
                mem_write_r <= i_write[pick_idx_s];
                mem_addr_r  <= i_addr[pick_idx_s*ADDR_W +: ADDR_W];
                mem_bank_r  <= i_bank[pick_idx_s];
                mem_wdata_r <= i_wdata[pick_idx_s*8 +: 8];
            end else if (ack_set_s || err_set_s) begin
                grant_r <= '0;
            end
            if (capture_s) begin
                rdata_r <= i_mem_rdata;
            end
        end
    end

    assign o_ack       = ack_r;
    assign o_grant     = grant_r;
    assign o_rdata     = rdata_r;
    assign o_mem_cs_n  = mem_cs_n_r;
    assign o_mem_write = mem_write_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_bank  = mem_bank_r;
    assign o_mem_wdata = mem_wdata_r;

endmodule
